// File: rtl/lstm_upd_ctrl.sv
// ============================================================================
// Module   : lstm_upd_ctrl
// Function : LSTM weight-update sequencer; CLR, then ACC/WR/DRAIN per row.
// Option   : LSTM_UPD_CTRL_PERF_EN adds the o_cycles busy-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lstm_upd_ctrl #(
   parameter int TIMESTEP  = 7,
   parameter int DELAY     = 3,
   parameter int L1_ROWS   = 2809,
   parameter int L2_ROWS   = 424,
   parameter int CNT_WIDTH = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic        agen_rst,
   output logic        en_1,
   output logic        en_2,
   output logic        update,
   output logic        bp,
   output logic        wr_1,
   output logic        wr_2,
   output logic        busy,
   output logic        done
`ifdef LSTM_UPD_CTRL_PERF_EN
   ,
   output logic [31:0] o_cycles
`endif
);

   localparam int MAX_ROWS = (L1_ROWS > L2_ROWS) ? L1_ROWS : L2_ROWS;
   localparam int TW       = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
   localparam int DW       = (DELAY > 2) ? $clog2(DELAY - 1) : 1;

   localparam logic [CNT_WIDTH-1:0] L1_C   = CNT_WIDTH'(L1_ROWS);
   localparam logic [CNT_WIDTH-1:0] L2_C   = CNT_WIDTH'(L2_ROWS);
   localparam logic [CNT_WIDTH-1:0] MAX_C  = CNT_WIDTH'(MAX_ROWS);
   localparam logic [TW-1:0]        T_LAST = TW'(TIMESTEP - 1);
   localparam logic [DW-1:0]        D_LAST = DW'((DELAY > 1) ? DELAY - 2 : 0);
   localparam logic                 NO_ROWS = (MAX_ROWS == 0);
   localparam logic                 NO_DRAIN = (DELAY == 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_ACC   = 3'd2,
      S_WR    = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
   logic [CNT_WIDTH-1:0] row_inc;
   logic [TW-1:0]        t_cnt_q, t_cnt_d;
   logic [DW-1:0]        d_cnt_q, d_cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         row_cnt_q <= '0;
         t_cnt_q   <= '0;
         d_cnt_q   <= '0;
      end else begin
         state_q   <= state_d;
         row_cnt_q <= row_cnt_d;
         t_cnt_q   <= t_cnt_d;
         d_cnt_q   <= d_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      row_cnt_d = row_cnt_q;
      t_cnt_d   = t_cnt_q;
      d_cnt_d   = d_cnt_q;
      row_inc   = row_cnt_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLR;
         end
         S_CLR: begin
            row_cnt_d = '0;
            t_cnt_d   = '0;
            d_cnt_d   = '0;
            state_d   = NO_ROWS ? S_DONE : S_ACC;
         end
         S_ACC: begin
            if (t_cnt_q == T_LAST) begin
               t_cnt_d = '0;
               state_d = S_WR;
            end else begin
               t_cnt_d = t_cnt_q + 1'b1;
            end
         end
         S_WR: begin
            row_cnt_d = row_inc;
            d_cnt_d   = '0;
            if (NO_DRAIN) state_d = (row_inc == MAX_C) ? S_DONE : S_ACC;
            else          state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // row_cnt already points at the next row while the pipeline empties
            if (d_cnt_q == D_LAST) begin
               d_cnt_d = '0;
               state_d = (row_cnt_q == MAX_C) ? S_DONE : S_ACC;
            end else begin
               d_cnt_d = d_cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d   = S_IDLE;
         row_cnt_d = '0;
         t_cnt_d   = '0;
         d_cnt_d   = '0;
      end
   end

   logic in_row;
   logic act_1;
   logic act_2;

   always_comb begin
      in_row   = (state_q == S_ACC) || (state_q == S_WR) || (state_q == S_DRAIN);
      act_1    = (row_cnt_q < L1_C);
      act_2    = (row_cnt_q < L2_C);
      agen_rst = (state_q == S_IDLE) || (state_q == S_CLR) || (state_q == S_DONE);
      busy     = in_row || (state_q == S_CLR);
      update   = in_row;
      en_1     = in_row && act_1;
      en_2     = in_row && act_2;
      wr_1     = (state_q == S_WR) && act_1;
      wr_2     = (state_q == S_WR) && act_2;
      done     = (state_q == S_DONE);
      bp       = 1'b0;
   end

`ifdef LSTM_UPD_CTRL_PERF_EN
   logic [31:0] cycles_q, cycles_d;

   always_comb begin
      cycles_d = cycles_q;
      if ((state_q == S_IDLE) && start && !abort) cycles_d = '0;
      else if (busy && (cycles_q != 32'hFFFF_FFFF)) cycles_d = cycles_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) cycles_q <= '0;
      else     cycles_q <= cycles_d;
   end

   assign o_cycles = cycles_q;
`else
   // Performance counter not built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_lstm_upd_ctrl.sv
// ============================================================================
// Module   : tb_lstm_upd_ctrl
// Function : Directed bench for lstm_upd_ctrl (three parameter sets).
// Option   : LSTM_UPD_CTRL_PERF_EN enables the o_cycles checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lstm_upd_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, abort_a = 1'b0;
   logic start_b = 1'b0, abort_b = 1'b0;
   logic start_z = 1'b0, abort_z = 1'b0;

   logic agen_rst_a, en_1_a, en_2_a, update_a, bp_a, wr_1_a, wr_2_a, busy_a, done_a;
   logic agen_rst_b, en_1_b, en_2_b, update_b, bp_b, wr_1_b, wr_2_b, busy_b, done_b;
   logic agen_rst_z, en_1_z, en_2_z, update_z, bp_z, wr_1_z, wr_2_z, busy_z, done_z;
`ifdef LSTM_UPD_CTRL_PERF_EN
   logic [31:0] cyc_a, cyc_b, cyc_z;
`endif

   always #5 clk = ~clk;

   lstm_upd_ctrl #(.TIMESTEP(3), .DELAY(3), .L1_ROWS(4), .L2_ROWS(2), .CNT_WIDTH(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
      .agen_rst(agen_rst_a), .en_1(en_1_a), .en_2(en_2_a), .update(update_a), .bp(bp_a),
      .wr_1(wr_1_a), .wr_2(wr_2_a), .busy(busy_a), .done(done_a)
`ifdef LSTM_UPD_CTRL_PERF_EN
      , .o_cycles(cyc_a)
`endif
   );

   lstm_upd_ctrl #(.TIMESTEP(3), .DELAY(1), .L1_ROWS(4), .L2_ROWS(2), .CNT_WIDTH(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
      .agen_rst(agen_rst_b), .en_1(en_1_b), .en_2(en_2_b), .update(update_b), .bp(bp_b),
      .wr_1(wr_1_b), .wr_2(wr_2_b), .busy(busy_b), .done(done_b)
`ifdef LSTM_UPD_CTRL_PERF_EN
      , .o_cycles(cyc_b)
`endif
   );

   lstm_upd_ctrl #(.TIMESTEP(3), .DELAY(3), .L1_ROWS(0), .L2_ROWS(0), .CNT_WIDTH(2)) dut_z (
      .clk(clk), .rst(rst), .start(start_z), .abort(abort_z),
      .agen_rst(agen_rst_z), .en_1(en_1_z), .en_2(en_2_z), .update(update_z), .bp(bp_z),
      .wr_1(wr_1_z), .wr_2(wr_2_z), .busy(busy_z), .done(done_z)
`ifdef LSTM_UPD_CTRL_PERF_EN
      , .o_cycles(cyc_z)
`endif
   );

   // Bit order: agen_rst en_1 en_2 update wr_1 wr_2 busy done
   logic [7:0] va, vb, vz;
   assign va = {agen_rst_a, en_1_a, en_2_a, update_a, wr_1_a, wr_2_a, busy_a, done_a};
   assign vb = {agen_rst_b, en_1_b, en_2_b, update_b, wr_1_b, wr_2_b, busy_b, done_b};
   assign vz = {agen_rst_z, en_1_z, en_2_z, update_z, wr_1_z, wr_2_z, busy_z, done_z};

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int         cyc;
      logic [7:0] exp;
   } vec_t;

   localparam int NVEC = 15;
   vec_t tbl[NVEC];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Steps n cycles on one instance, tallying busy/wr/done; cycle 0 is the current one.
   task automatic run(input int sel, input int n, input bit hold,
                      output int bc, output int w1, output int w2,
                      output int dc, output int dcyc);
      logic [7:0] v;
      bc = 0; w1 = 0; w2 = 0; dc = 0; dcyc = -1;
      for (int k = 0; k < n; k++) begin
         if (k == 1 && !hold) begin
            start_a = 1'b0; start_b = 1'b0; start_z = 1'b0;
         end
         v = (sel == 0) ? va : (sel == 1) ? vb : vz;
         bc += int'(v[1]);
         w1 += int'(v[3]);
         w2 += int'(v[2]);
         dc += int'(v[0]);
         if (v[0] && dcyc < 0) dcyc = k;
         tick();
      end
   endtask

   initial begin
      int bc, w1, w2, dc, dcyc;
      int idx, first_wr, last_wr, bad_sp, en2_last;

      tbl[0]  = '{0,  8'h80};  tbl[1]  = '{1,  8'h82};  tbl[2]  = '{2,  8'h72};
      tbl[3]  = '{4,  8'h72};  tbl[4]  = '{5,  8'h7E};  tbl[5]  = '{6,  8'h72};
      tbl[6]  = '{11, 8'h7E};  tbl[7]  = '{12, 8'h52};  tbl[8]  = '{17, 8'h5A};
      tbl[9]  = '{22, 8'h52};  tbl[10] = '{23, 8'h5A};  tbl[11] = '{24, 8'h12};
      tbl[12] = '{25, 8'h12};  tbl[13] = '{26, 8'h81};  tbl[14] = '{27, 8'h80};

      // Reset, then idle
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (5) tick();
      chk("idle_a", {24'd0, va}, 32'h80);
      chk("idle_b", {24'd0, vb}, 32'h80);
      chk("idle_z", {24'd0, vz}, 32'h80);
      chk("bp_idle", {29'd0, bp_a, bp_b, bp_z}, 32'd0);
`ifdef LSTM_UPD_CTRL_PERF_EN
      chk("cyc_reset", cyc_a, 32'd0);
`endif

      // Full pass on A against the cycle table
      idx = 0; first_wr = -1; last_wr = -1; bad_sp = 0; en2_last = -1;
      bc = 0; w1 = 0; w2 = 0; dc = 0;
      start_a = 1'b1;
      for (int k = 0; k <= 27; k++) begin
         if (k == 1) start_a = 1'b0;
         if (idx < NVEC && tbl[idx].cyc == k) begin
            chk($sformatf("pass_a_cyc%0d", k), {24'd0, va}, {24'd0, tbl[idx].exp});
            idx++;
         end
         if (va[3]) begin
            if (first_wr < 0) first_wr = k;
            else if (k - last_wr != 6) bad_sp++;
            last_wr = k;
         end
         if (va[5]) en2_last = k;
         bc += int'(va[1]); w1 += int'(va[3]); w2 += int'(va[2]); dc += int'(va[0]);
         tick();
      end
      chk("a_busy_cycles", bc, 25);
      chk("a_wr1_count", w1, 4);
      chk("a_wr2_count", w2, 2);
      chk("a_done_count", dc, 1);
      chk("a_first_wr", first_wr, 5);
      chk("a_wr_spacing_bad", bad_sp, 0);
      chk("a_en2_last_high", en2_last, 11);
`ifdef LSTM_UPD_CTRL_PERF_EN
      chk("cyc_after_done", cyc_a, 32'd25);
      repeat (4) tick();
      chk("cyc_hold", cyc_a, 32'd25);
`endif

      // DELAY=1 variant
      start_b = 1'b1;
      run(1, 20, 1'b0, bc, w1, w2, dc, dcyc);
      chk("b_busy_cycles", bc, 17);
      chk("b_wr1_count", w1, 4);
      chk("b_wr2_count", w2, 2);
      chk("b_done_cycle", dcyc, 18);

      // Abort in the 2nd cycle of the 3rd ACC (cycle 15)
      start_a = 1'b1;
      run(0, 15, 1'b0, bc, w1, w2, dc, dcyc);
      chk("abort_pre_wr1", w1, 2);
      abort_a = 1'b1;
      tick();
      chk("abort_to_idle", {24'd0, va}, 32'h80);
      start_a = 1'b1;
      tick();
      chk("abort_beats_start", {24'd0, va}, 32'h80);
      abort_a = 1'b0;
      run(0, 28, 1'b0, bc, w1, w2, dc, dcyc);
      chk("post_abort_busy", bc, 25);
      chk("post_abort_wr1", w1, 4);
      chk("post_abort_done_cycle", dcyc, 26);

      // start held high across two back-to-back passes
      start_a = 1'b1;
      run(0, 55, 1'b1, bc, w1, w2, dc, dcyc);
      chk("held_busy", bc, 50);
      chk("held_wr1", w1, 8);
      chk("held_wr2", w2, 4);
      chk("held_done_count", dc, 2);
      chk("held_first_done", dcyc, 26);
      chk("held_third_clr", {24'd0, va}, 32'h82);
      start_a = 1'b0;
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      chk("held_abort_idle", {24'd0, va}, 32'h80);

      // Zero-row configuration: CLR goes straight to DONE
      start_z = 1'b1;
      tick();
      start_z = 1'b0;
      chk("z_clr", {24'd0, vz}, 32'h82);
      tick();
      chk("z_done", {24'd0, vz}, 32'h81);
      tick();
      chk("z_idle", {24'd0, vz}, 32'h80);

      // rst wins over abort
      start_a = 1'b1;
      repeat (3) tick();
      start_a = 1'b0;
      rst = 1'b1;
      abort_a = 1'b1;
      tick();
      rst = 1'b0;
      abort_a = 1'b0;
      chk("rst_idle", {24'd0, va}, 32'h80);
`ifdef LSTM_UPD_CTRL_PERF_EN
      chk("cyc_rst_clear", cyc_a, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no summary expected summary");
      $fatal(1);
   end

endmodule

`default_nettype wire
